// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives instruction memory via req/ack,
// and presents (if_pc, if_inst) to IF/ID with stall, branch redirect and flush handling.
`default_nettype none

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] req_addr, req_addr_next;
  logic [31:0] inst_buf, inst_buf_next;
  logic        pend_valid, pend_valid_next;
  logic [31:0] pend_target, pend_target_next;
  logic [31:0] seq_pc;
  logic [31:0] flush_pc;
  logic [31:0] br_pc;
  logic        advance;
  logic        flush_taken;

  logic unused_ok;
  assign unused_ok = ^{stall[5:1], new_pc[1:0], branch_target[1:0]};

  assign flush_pc = {new_pc[31:2], 2'b00};
  assign br_pc    = {branch_target[31:2], 2'b00};
  assign seq_pc   = pend_valid ? pend_target : (branch_flag ? br_pc : pc + 32'd4);

  assign inst_addr = req_addr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      req_addr    <= 32'h0;
      inst_buf    <= 32'h0;
      pend_valid  <= 1'b0;
      pend_target <= 32'h0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      req_addr    <= req_addr_next;
      inst_buf    <= inst_buf_next;
      pend_valid  <= pend_valid_next;
      pend_target <= pend_target_next;
    end
  end

  always_comb begin
    state_next       = state;
    pc_next          = pc;
    req_addr_next    = req_addr;
    inst_buf_next    = inst_buf;
    pend_valid_next  = pend_valid;
    pend_target_next = pend_target;
    advance          = 1'b0;
    flush_taken      = 1'b0;
    inst_req         = 1'b0;
    stallreq_if      = 1'b0;
    if_pc            = 32'h0;
    if_inst          = 32'h0;

    case (state)
      IDLE: begin
        state_next    = FETCH;
        req_addr_next = pc;
      end
      FETCH: begin
        inst_req    = 1'b1;
        stallreq_if = ~inst_ack;
        if (flush) begin
          flush_taken = 1'b1;
          pc_next     = flush_pc;
          if (inst_ack) req_addr_next = flush_pc;
          else          state_next    = DRAIN;
        end else if (inst_ack) begin
          if (!stall[0]) begin
            if_pc   = pc;
            if_inst = inst_rdata;
            advance = 1'b1;
          end else begin
            inst_buf_next = inst_rdata;
            state_next    = HOLD;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          flush_taken   = 1'b1;
          pc_next       = flush_pc;
          req_addr_next = flush_pc;
          state_next    = FETCH;
        end else begin
          if_pc   = pc;
          if_inst = inst_buf;
          if (!stall[0]) begin
            advance    = 1'b1;
            state_next = FETCH;
          end
        end
      end
      default: begin  // DRAIN: keep the outstanding request untouched until its ack
        inst_req    = 1'b1;
        stallreq_if = ~inst_ack;
        if (flush) begin
          flush_taken = 1'b1;
          pc_next     = flush_pc;
        end
        if (inst_ack) begin
          state_next    = FETCH;
          req_addr_next = flush ? flush_pc : pc;
        end
      end
    endcase

    if (flush_taken) begin
      pend_valid_next = 1'b0;
    end else if (advance) begin
      pc_next         = seq_pc;
      req_addr_next   = seq_pc;
      pend_valid_next = 1'b0;
    end else if (branch_flag) begin
      pend_valid_next  = 1'b1;
      pend_target_next = br_pc;
    end
  end

endmodule

`default_nettype wire
